rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource between 8 requesters.
- Picks a winner, holds the grant until release, done, or timeout, then advances the priority pointer.
- Produces the grant as a 3-bit index plus valid. These drive a decoder_3to8 instance, whose 8-bit one-hot output is the per-requester grant lines.
- Sits in front of any shared datapath unit (e.g. a shared adder) in the design.

---
 rtl/rr_arbiter_8_pkg.sv | 12 +
 rtl/rr_arbiter_8_decoder.sv | 13 +
 rtl/rr_arbiter_8.sv | 89 ++++++++
 tb/tb_rr_arbiter_8.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder with enable; all zeros when disabled.
module decoder_3to8 (
  input  logic [2:0] in,
  input  logic       enable,
  output logic [7:0] out
);

  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with done/withdraw/timeout release.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [2*N_REQ-2:0] req2;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W-1:0]   winner;

  logic expire;
  logic withdrew;
  logic release_now;

  // Rotate so bit 0 is ptr, take the lowest set bit, rotate back.
  always_comb begin
    req2   = {req[N_REQ-2:0], req};
    rot    = req2[ptr +: N_REQ];
    off    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    winner = ptr + off;
  end

  assign expire      = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign withdrew    = !req[grant_idx];
  assign release_now = done || withdrew || expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
            ptr         <= grant_idx + 3'd1;
            cnt         <= '0;
            timeout     <= expire && !done && !withdrew;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  decoder_3to8 u_dec (
    .in    (grant_idx),
    .enable(grant_valid),
    .out   (grant_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (MAX_HOLD=4).
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] grant_onehot;
  logic       timeout;

  int checks;
  int errors;

  rr_arbiter_8 #(
    .MAX_HOLD(4),
    .CNT_W   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_onehot(grant_onehot),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    #3;
    checks++;
    if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got gv=%b oh=%h to=%b exp 0 00 0",
               grant_valid, grant_onehot, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
      errors++;
      $display("FAIL reset_first got gv=%b idx=%0d oh=%h exp 1 0 01",
               grant_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] e_idx;
    logic [7:0] e_oh;
    for (int k = 0; k < 9; k++) begin
      e_idx = 3'(k % 8);
      e_oh  = 8'h01 << e_idx;
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== e_idx || grant_onehot !== e_oh) begin
        errors++;
        $display("FAIL rr_grant k=%0d got gv=%b idx=%0d oh=%h exp 1 %0d %h",
                 k, grant_valid, grant_idx, grant_onehot, e_idx, e_oh);
      end
      if (k < 8) begin
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL rr_bubble k=%0d got gv=%b to=%b exp 0 0",
                   k, grant_valid, timeout);
        end
        step();
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got gv=%b exp 0", grant_valid);
    end
  endtask

  task automatic test_wrap();
    req = 8'h20;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin
      errors++;
      $display("FAIL wrap_g5 got gv=%b idx=%0d exp 1 5", grant_valid, grant_idx);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h21;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
      errors++;
      $display("FAIL wrap_6to0 got gv=%b idx=%0d oh=%h exp 1 0 01",
               grant_valid, grant_idx, grant_onehot);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'h80;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd7 || grant_onehot !== 8'h80) begin
      errors++;
      $display("FAIL wrap_p0_7 got gv=%b idx=%0d oh=%h exp 1 7 80",
               grant_valid, grant_idx, grant_onehot);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();
  endtask

  task automatic test_timeout();
    req = 8'h08;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold c=%0d got gv=%b idx=%0d to=%b exp 1 3 0",
                 c, grant_valid, grant_idx, timeout);
      end
      step();
    end
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse got gv=%b to=%b exp 0 1", grant_valid, timeout);
    end
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_regrant got gv=%b idx=%0d to=%b exp 1 3 0",
               grant_valid, grant_idx, timeout);
    end
    req = 8'h00;
    step();
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_withdraw got gv=%b to=%b exp 0 0", grant_valid, timeout);
    end
    step();
  endtask

  task automatic test_withdraw();
    req = 8'h04;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL wd_g2 got gv=%b idx=%0d exp 1 2", grant_valid, grant_idx);
    end
    req = 8'h00;
    step();
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0 || grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL wd_rel got gv=%b to=%b idx=%0d exp 0 0 2",
               grant_valid, timeout, grant_idx);
    end
    req = 8'hFF;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd3) begin
      errors++;
      $display("FAIL wd_ptr3 got gv=%b idx=%0d exp 1 3", grant_valid, grant_idx);
    end
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_done_exp got gv=%b to=%b exp 0 0", grant_valid, timeout);
    end
    step();
  endtask

  task automatic test_async_reset();
    req = 8'h10;
    step();
    step();
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd4) begin
      errors++;
      $display("FAIL ar_g4 got gv=%b idx=%0d exp 1 4", grant_valid, grant_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got gv=%b oh=%h to=%b exp 0 00 0",
               grant_valid, grant_onehot, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || grant_onehot !== 8'h10) begin
      errors++;
      $display("FAIL ar_regrant got gv=%b idx=%0d oh=%h exp 1 4 10",
               grant_valid, grant_idx, grant_onehot);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
